// File: rtl/fetch_decode_queue_pkg.sv
// Shared types for the fetch -> decode instruction queue.
//   fdq_entry_t : one queued {pc, instr} pair at the system-wide widths.
// WORD / INSTR_LEN normally come from the shared global definitions; the
// fallbacks below only apply when this package is built on its own.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package fetch_decode_queue_pkg;

  localparam int FDQ_WORD      = `WORD;
  localparam int FDQ_INSTR_LEN = `INSTR_LEN;

  typedef struct packed {
    logic [FDQ_WORD-1:0]      pc;
    logic [FDQ_INSTR_LEN-1:0] instr;
  } fdq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// fdq_storage: DEPTH-entry register array for the fetch/decode queue.
//   clk    : write clock
//   we     : write enable, entry written at waddr on the rising edge
//   waddr  : write index
//   wdata  : entry to write
//   raddr  : asynchronous read index
//   rdata  : entry at raddr (combinational)
// Contents are deliberately not reset; the owner tracks validity.
module fdq_storage
  import fetch_decode_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fdq_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t [DEPTH-1:0] mem_q;
  entry_t [DEPTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: first-word-fall-through FIFO between fetch and decode.
//   clk, reset         : clock, asynchronous active-low reset
//   in_valid/in_ready  : fetch-side handshake, in_pc/in_instr payload
//   out_valid/out_ready: decode-side handshake, out_pc/out_instr = head entry
//   flush              : taken branch, drops every queued entry
//   count              : current occupancy (0..DEPTH)
// All outputs are functions of registered state only, so there is no
// combinational path from any input to any output. DEPTH must be a power
// of two (>= 2) so the pointers wrap by plain overflow.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int  DEPTH     = 4,
  parameter int  WORD      = `WORD,
  parameter int  INSTR_LEN = `INSTR_LEN,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WORD-1:0]      in_pc,
  input  logic [INSTR_LEN-1:0] in_instr,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WORD-1:0]      out_pc,
  output logic [INSTR_LEN-1:0] out_instr,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [CW-1:0]        count
);

  // Same layout as fdq_entry_t, but tracks per-instance width overrides.
  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [INSTR_LEN-1:0] instr;
  } entry_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push, pop;
  entry_t        wr_entry, rd_entry;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);

  // Flush wins over both handshakes, so neither a write nor a pointer move
  // can sneak through in the flush cycle.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  fdq_storage #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign out_pc    = rd_entry.pc;
  assign out_instr = rd_entry.instr;
  assign count     = count_q;

endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter WORD, default 64, PC width in bits.
REQ-003 Parameter INSTR_LEN, default 32, instruction width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 in_valid  input  1  fetch presents an entry.
REQ-007 in_pc  input  WORD  PC of the presented instruction.
REQ-008 in_instr  input  INSTR_LEN  presented instruction word.
REQ-009 in_ready  output  1  queue accepts an entry this cycle.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_pc  output  WORD  PC of head entry.
REQ-012 out_instr  output  INSTR_LEN  instruction of head entry.
REQ-013 out_ready  input  1  decode consumes head this cycle; low = decode stall.
REQ-014 flush  input  1  branch taken; discard all queued entries.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push SHALL occur when in_valid and in_ready are both 1 at a rising edge; pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal (count < DEPTH), combinational from state only; no push-through when full, even if a pop occurs.
REQ-018 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL show the entry at the read pointer (first-word fall-through), combinational from state only.
REQ-019 Latency: an entry pushed at edge N SHALL be visible on out_* after edge N when the queue was empty; no same-cycle input-to-output path.
REQ-020 Entries SHALL leave in push order; {pc, instr} pairs SHALL never be split or reordered.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-022 Pop with count == 0 SHALL be ignored; push with count == DEPTH SHALL be ignored.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 flush SHALL take priority: at an edge with flush = 1, count and both pointers SHALL go to 0, and any same-cycle push or pop SHALL be discarded.
REQ-025 While out_valid = 1 and out_ready = 0, out_pc/out_instr SHALL hold stable until popped or flushed.
REQ-026 Storage contents SHALL NOT be cleared by flush; only pointers and count change.

Reset
REQ-027 While reset = 0: count = 0, both pointers = 0, in_ready = 1, out_valid = 0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately; out_pc/out_instr SHALL then be don't-care while out_valid = 0.
REQ-029 Storage array SHALL NOT require reset.

Structure
REQ-030 Entry typedef fdq_entry_t {pc [WORD-1:0], instr [INSTR_LEN-1:0]} SHALL live in a shared package; WORD and INSTR_LEN defaults SHALL come from the existing shared `WORD / `INSTR_LEN definitions.
REQ-031 One sub-module fdq_storage (DEPTH x fdq_entry_t register array: one write port, one async read port) SHALL hold the data; pointer, count and handshake logic stay in fetch_decode_queue.

Verification
REQ-032 Reset, then push PC 0/F84402C9, PC 4/8B09026A with out_ready = 0 -> count = 2, out_pc = 0, out_instr = F84402C9 held stable.
REQ-033 With DEPTH = 4, push 5 entries (PC 0,4,8,12,16) with out_ready = 0 -> in_ready = 0 after the 4th push, count = 4, PC 16 not stored.
REQ-034 Full queue: one pop with in_valid = 1 -> count = 3, in_ready = 1 next cycle, head PC = 4; the push offered in the pop cycle is not accepted.
REQ-035 Push and pop continuously for 10 entries (PC 0..36) with out_ready = 1 -> output order PC 0..36 with correct instructions across pointer wrap; count steady at 1.
REQ-036 count = 3, then flush with in_valid = 1 and out_ready = 1 in the same cycle -> next cycle count = 0, out_valid = 0, no entry written; the next push (PC 64) appears at the head.
REQ-037 count = 2, then reset driven low between clock edges -> out_valid = 0 and count = 0 immediately, before the next edge.
